// File: rtl/render_compositor.sv
// rtl/render_compositor.sv - two-stage per-pixel object hit compositor with priority merge
module render_compositor #(
    parameter int OBJS        = 4,
    parameter int SETS        = 2,
    parameter int FB_WIDTH    = 640,
    parameter int SCALE_SHIFT = 1,
    parameter int ADDR_W      = 19
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    input  logic [OBJS-1:0]        obj_en,
    input  logic [OBJS-1:0]        is_static,
    input  logic [OBJS-1:0][10:0]  x1,
    input  logic [OBJS-1:0][10:0]  x2,
    input  logic [OBJS-1:0][9:0]   y1,
    input  logic [OBJS-1:0][9:0]   y2,
    input  logic                   flush_in,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic [1:0]             color_bits,
    output logic [ADDR_W-1:0]      write_address
);

    localparam int SW = (SETS > 1) ? $clog2(SETS) : 1;
    localparam logic [SW-1:0] LAST_SET = SW'(SETS - 1);

    logic [SW-1:0]     set_cnt;
    logic              accept;
    logic [OBJS-1:0]   hit;
    logic [ADDR_W-1:0] addr_now;

    logic              s1_valid;
    logic [OBJS-1:0]   s1_hit;
    logic [OBJS-1:0]   s1_static;
    logic [SW-1:0]     s1_set;
    logic [ADDR_W-1:0] s1_addr;

    logic              acc_found;
    logic              acc_static;
    logic [ADDR_W-1:0] acc_addr;
    logic              s2_done;
    logic              mrg_found;
    logic              mrg_static;

    always_comb begin
        ready_out = !(valid_out && !ready_in);
        accept    = valid_in && ready_out && !flush_in;
        addr_now  = ADDR_W'(hcount_in >> SCALE_SHIFT)
                  + ADDR_W'(FB_WIDTH) * ADDR_W'(vcount_in >> SCALE_SHIFT);
        for (int i = 0; i < OBJS; i++) begin
            hit[i] = obj_en[i] && (x1[i] <= hcount_in) && (hcount_in <= x2[i])
                               && (y1[i] <= vcount_in) && (vcount_in <= y2[i]);
        end
    end

    // A set-0 beat starts from an empty accumulator; an existing winner is never displaced.
    always_comb begin
        mrg_found  = (s1_set == '0) ? 1'b0 : acc_found;
        mrg_static = (s1_set == '0) ? 1'b0 : acc_static;
        if (!mrg_found) begin
            for (int i = OBJS - 1; i >= 0; i--) begin
                if (s1_hit[i]) begin
                    mrg_found  = 1'b1;
                    mrg_static = s1_static[i];
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            set_cnt   <= '0;
            s1_valid  <= 1'b0;
            s1_hit    <= '0;
            s1_static <= '0;
            s1_set    <= '0;
            s1_addr   <= '0;
        end else if (flush_in) begin
            set_cnt  <= '0;
            s1_valid <= 1'b0;
        end else if (ready_out) begin
            s1_valid <= accept;
            if (accept) begin
                s1_hit    <= hit;
                s1_static <= is_static;
                s1_set    <= set_cnt;
                if (set_cnt == '0) s1_addr <= addr_now;
                set_cnt <= (set_cnt == LAST_SET) ? '0 : set_cnt + SW'(1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            acc_found  <= 1'b0;
            acc_static <= 1'b0;
            acc_addr   <= '0;
            s2_done    <= 1'b0;
        end else if (flush_in) begin
            acc_found  <= 1'b0;
            acc_static <= 1'b0;
            s2_done    <= 1'b0;
        end else if (ready_out) begin
            s2_done <= s1_valid && (s1_set == LAST_SET);
            if (s1_valid) begin
                acc_found  <= mrg_found;
                acc_static <= mrg_static;
                if (s1_set == '0) acc_addr <= s1_addr;
            end
        end
    end

    // ready_out high means the output register is empty or draining this edge.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_out     <= 1'b0;
            color_bits    <= 2'b00;
            write_address <= '0;
        end else if (s2_done && ready_out && !flush_in) begin
            valid_out     <= 1'b1;
            color_bits    <= acc_found ? (acc_static ? 2'b10 : 2'b01) : 2'b11;
            write_address <= acc_addr;
        end else if (valid_out && ready_in) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_render_compositor.sv
// tb/tb_render_compositor.sv - directed self-checking bench for render_compositor
module tb_render_compositor;
    localparam int OBJS   = 4;
    localparam int ADDR_W = 19;

    logic                  clk_in = 1'b0;
    logic                  rst_in, valid_in, ready_out, flush_in, valid_out, ready_in;
    logic [10:0]           hcount_in;
    logic [9:0]            vcount_in;
    logic [OBJS-1:0]       obj_en, is_static;
    logic [OBJS-1:0][10:0] x1, x2;
    logic [OBJS-1:0][9:0]  y1, y2;
    logic [1:0]            color_bits;
    logic [ADDR_W-1:0]     write_address;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int q_col[$];
    int q_addr[$];
    int q_cyc[$];

    render_compositor dut (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready_out),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .obj_en(obj_en), .is_static(is_static),
        .x1(x1), .x2(x2), .y1(y1), .y2(y2), .flush_in(flush_in), .valid_out(valid_out),
        .ready_in(ready_in), .color_bits(color_bits), .write_address(write_address)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc = cyc + 1;

    always @(negedge clk_in) begin
        if (!rst_in && valid_out && ready_in) begin
            q_col.push_back(int'(color_bits));
            q_addr.push_back(int'(write_address));
            q_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_objs();
        obj_en = '0; is_static = '0;
        x1 = '0; x2 = '0; y1 = '0; y2 = '0;
    endtask

    task automatic set_obj(input int s, input bit st, input int a, input int b, input int c, input int d);
        obj_en[s] = 1'b1; is_static[s] = st;
        x1[s] = 11'(a); x2[s] = 11'(b); y1[s] = 10'(c); y2[s] = 10'(d);
    endtask

    task automatic beat(input int hc, input int vc);
        int n;
        n = 0;
        hcount_in = 11'(hc); vcount_in = 10'(vc); valid_in = 1'b1;
        while (!ready_out && n < 100) begin
            @(posedge clk_in); #1;
            n++;
        end
        if (n >= 100) check("beat_timeout", 0, 1);
        @(posedge clk_in); #1;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) begin
            @(posedge clk_in); #1;
        end
    endtask

    task automatic get_result(input string tag, input int ecol, input int eaddr, output int c);
        int n;
        n = 0;
        c = 0;
        while (q_col.size() == 0 && n < 50) begin
            @(posedge clk_in); #1;
            n++;
        end
        if (q_col.size() == 0) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            check({tag, "_col"}, q_col.pop_front(), ecol);
            check({tag, "_addr"}, q_addr.pop_front(), eaddr);
            c = q_cyc.pop_front();
        end
    endtask

    initial begin
        int c, cprev, ecol;
        rst_in = 1'b1; valid_in = 1'b0; flush_in = 1'b0; ready_in = 1'b1;
        hcount_in = '0; vcount_in = '0;
        clear_objs();
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_valid", valid_out, 0);
        check("rst_color", color_bits, 0);
        check("rst_addr", write_address, 0);
        check("rst_ready", ready_out, 1);
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        check("post_rst_ready", ready_out, 1);

        // single static hit in set 0, exact latency
        clear_objs(); set_obj(1, 1, 90, 110, 40, 60);
        beat(100, 50);
        clear_objs();
        beat(100, 50);
        valid_in = 1'b0;
        check("lat_0", valid_out, 0);
        @(posedge clk_in); #1;
        check("lat_1", valid_out, 0);
        @(posedge clk_in); #1;
        check("lat_2", valid_out, 1);
        check("lat_2_col", color_bits, 2);
        check("lat_2_addr", write_address, 16050);
        get_result("p043", 2, 16050, c);

        // set priority, slot priority, background
        clear_objs(); set_obj(3, 0, 0, 2047, 0, 1023);
        beat(100, 50);
        clear_objs(); set_obj(0, 1, 0, 2047, 0, 1023);
        beat(100, 50);
        clear_objs();
        beat(200, 100); beat(200, 100);
        clear_objs(); set_obj(1, 0, 0, 2047, 0, 1023); set_obj(2, 1, 0, 2047, 0, 1023);
        beat(100, 50);
        clear_objs();
        beat(100, 50);
        clear_objs(); set_obj(1, 1, 0, 2047, 0, 1023); set_obj(3, 0, 0, 2047, 0, 1023);
        beat(100, 50); beat(100, 50);
        idle(4);
        get_result("setprio", 1, 16050, c);
        get_result("bg", 3, 32100, c);
        get_result("slotprio_a", 1, 16050, c);
        get_result("slotprio_b", 2, 16050, c);

        // single-point and inverted boxes
        clear_objs(); set_obj(0, 1, 100, 100, 50, 50);
        beat(100, 50); beat(100, 50);
        beat(101, 50); beat(101, 50);
        beat(100, 51); beat(100, 51);
        beat(99, 50);  beat(99, 50);
        clear_objs(); set_obj(0, 1, 110, 90, 40, 60); set_obj(1, 0, 90, 110, 60, 40);
        beat(100, 50); beat(100, 50);
        idle(4);
        get_result("pt_hit", 2, 16050, c);
        get_result("pt_x1", 3, 16050, c);
        get_result("pt_y1", 3, 16050, c);
        get_result("pt_xm1", 3, 16049, c);
        get_result("inverted", 3, 16050, c);

        // streaming without bubbles
        clear_objs(); set_obj(0, 1, 0, 30, 0, 1023);
        for (int k = 0; k < 8; k++) begin
            beat(10 * k, 2 * k);
            beat(10 * k, 2 * k);
        end
        idle(4);
        cprev = 0;
        for (int k = 0; k < 8; k++) begin
            ecol = (10 * k <= 30) ? 2 : 3;
            get_result($sformatf("stream%0d", k), ecol, 645 * k, c);
            if (k > 0) check($sformatf("stream_gap%0d", k), c - cprev, 2);
            cprev = c;
        end

        // backpressure
        ready_in = 1'b0;
        clear_objs(); set_obj(2, 1, 0, 2047, 0, 1023);
        beat(40, 20); beat(40, 20);
        clear_objs();
        beat(60, 30); beat(60, 30);
        valid_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall_ready%0d", k), ready_out, 0);
            check($sformatf("stall_valid%0d", k), valid_out, 1);
            check($sformatf("stall_col%0d", k), color_bits, 2);
            check($sformatf("stall_addr%0d", k), write_address, 6420);
            @(posedge clk_in); #1;
        end
        ready_in = 1'b1;
        get_result("stall_a", 2, 6420, c);
        get_result("stall_b", 3, 9630, c);
        idle(3);
        check("stall_extra", q_col.size(), 0);

        // flush after set-0 beat, with a colliding valid beat
        clear_objs(); set_obj(0, 1, 0, 2047, 0, 1023);
        beat(100, 50);
        flush_in = 1'b1;
        @(posedge clk_in); #1;
        flush_in = 1'b0;
        clear_objs();
        beat(300, 200); beat(300, 200);
        idle(5);
        get_result("flush", 3, 64150, c);
        check("flush_extra", q_col.size(), 0);

        // reset mid-pixel
        clear_objs(); set_obj(0, 1, 0, 2047, 0, 1023);
        beat(100, 50);
        valid_in = 1'b0;
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        clear_objs(); set_obj(1, 0, 0, 2047, 0, 1023);
        beat(300, 200);
        clear_objs();
        beat(300, 200);
        idle(5);
        get_result("rst_mid", 1, 64150, c);
        check("rst_extra", q_col.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/render_compositor.md
RENDER_COMPOSITOR -- requirements
Module: render_compositor

Interface
REQ-001 Parameter OBJS, default 4: object slots presented per beat.
REQ-002 Parameter SETS, default 2: beats per pixel (OBJS*SETS objects per pixel).
REQ-003 Parameter FB_WIDTH, default 640: framebuffer row pitch, in words.
REQ-004 Parameter SCALE_SHIFT, default 1: right shift applied to hcount/vcount when forming the address.
REQ-005 Parameter ADDR_W, default 19: write address width.
REQ-006 clk_in  input  1  sole clock, rising edge.
REQ-007 rst_in  input  1  reset, asynchronous, active-high.
REQ-008 valid_in  input  1  beat valid.
REQ-009 ready_out  output  1  block accepts a beat this cycle.
REQ-010 hcount_in  input  11  pixel x.
REQ-011 vcount_in  input  10  pixel y.
REQ-012 obj_en  input  OBJS  per-slot object present.
REQ-013 is_static  input  OBJS  per-slot static flag.
REQ-014 x1, x2  input  OBJS x 11  per-slot inclusive x bounds.
REQ-015 y1, y2  input  OBJS x 10  per-slot inclusive y bounds.
REQ-016 flush_in  input  1  synchronous abort of the partial pixel.
REQ-017 valid_out  output  1  result valid.
REQ-018 ready_in  input  1  downstream accepts the result.
REQ-019 color_bits  output  2  01 = movable, 10 = static, 11 = background.
REQ-020 write_address  output  ADDR_W  framebuffer word address.

Function
REQ-021 A beat is accepted when valid_in and ready_out are both high on a rising edge.
REQ-022 ready_out = NOT (valid_out AND NOT ready_in), combinational.
REQ-023 Stage 1 registers, per slot: hit = obj_en AND x1<=hcount_in<=x2 AND y1<=vcount_in<=y2, using unsigned compares; it also registers is_static and the beat's set index.
REQ-024 A slot with x1>x2 or y1>y2 never hits.
REQ-025 A 0..SETS-1 set counter increments per accepted beat and wraps to 0 after SETS-1.
REQ-026 On a set-0 beat, the address (hcount_in>>SCALE_SHIFT) + FB_WIDTH*(vcount_in>>SCALE_SHIFT) is captured, truncated to ADDR_W.
REQ-027 Coordinates on beats other than set 0 are used only for hit tests; upstream holds the pixel constant across the SETS beats.
REQ-028 Stage 2 accumulates the winner: the lowest set index wins; within a set, the lowest slot index wins; later hits never override an earlier winner.
REQ-029 Stage 2 clears its accumulator on every set-0 beat before merging that beat.
REQ-030 The winner's color is 10 if static, else 01; with no hit across all SETS beats, the color is 11.
REQ-031 After the stage-2 merge of set SETS-1, the result registers load color_bits and write_address and assert valid_out.
REQ-032 Latency: valid_out rises 2 cycles after the edge that accepted the last beat.
REQ-033 valid_out and its data hold stable until valid_out AND ready_in; valid_out then drops unless a new result loads on the same edge.
REQ-034 While stalled (ready_out low), stage 1, stage 2 and the set counter hold.
REQ-035 Full throughput: with ready_in held high, one result is produced per SETS accepted beats with no bubbles.
REQ-036 flush_in high on an edge resets the set counter to 0, invalidates stage 1 and stage 2, and drops any beat accepted that cycle.
REQ-037 flush_in does not clear a pending valid_out.
REQ-038 flush_in has priority over a simultaneous valid_in.
REQ-039 OBJS=1 and SETS=1 are legal; with SETS=1, every beat is a set-0 and last beat.

Reset
REQ-040 On rst_in high, asynchronously: valid_out=0, color_bits=00, write_address=0, set counter=0, stage 1 and 2 invalid, accumulator cleared.
REQ-041 ready_out reads 1 during and after reset.
REQ-042 Reset mid-pixel discards the partial pixel; the first beat accepted after reset is treated as set 0.

Verification
REQ-043 OBJS=4, SETS=2, ready_in=1; pixel (100,50); slot1 of set 0 box (90..110, 40..60) static; all else disabled -> color 10, address 50+640*25=16050, 2 cycles after the second beat.
REQ-044 Same pixel; set 0 slot3 movable hit and set 1 slot0 static hit -> color 01 (set 0 wins); next pixel with no hits -> color 11.
REQ-045 Streaming 8 pixels back-to-back with ready_in=1 -> 8 results on consecutive SETS-cycle spacing, no bubbles.
REQ-046 Hold ready_in=0 for 5 cycles while a result is pending -> ready_out=0, valid_out and data stable, no beats lost; resume -> order preserved.
REQ-047 Assert flush_in after the set-0 beat, then send a fresh pixel -> only the fresh pixel's result appears; reset mid-pixel behaves the same.
REQ-048 Box x1=x2=100, y1=y2=50 -> hit only at (100,50); inverted box x1=110, x2=90 -> never hits.
